// File: rtl/aurora_ddr_wr_pack_pkg.sv
// Shared sizing helpers for the Aurora RX -> DDR write packer.
// Optional flush support is selected with the PACKER_FLUSH_EN macro.
package aurora_ddr_wr_pack_pkg;

  // Number of input lanes per DDR word.
  function automatic int ratio_f(input int in_w, input int out_w);
    return out_w / in_w;
  endfunction

  // Lane counter width.
  function automatic int cnt_w_f(input int ratio);
    return $clog2(ratio);
  endfunction

  // FIFO level / pointer width (extra msb distinguishes full from empty).
  function automatic int lvl_w_f(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int KEEP_MAX = 64;

  // Low 'lanes' bits set; callers truncate to RATIO bits.
  function automatic logic [KEEP_MAX-1:0] keep_mask(input int lanes);
    return (lanes >= KEEP_MAX) ? '1 : ((KEEP_MAX'(1) << lanes) - KEEP_MAX'(1));
  endfunction

endpackage

// File: rtl/aurora_ddr_wr_pack_fifo.sv
// Synchronous first-word-fall-through FIFO with synchronous clear.
// Pointers carry one extra msb so full and empty are distinguishable.
module aurora_ddr_wr_pack_fifo #(
  parameter int W     = 512,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clr,
  input  logic                     push,
  input  logic [W-1:0]             din,
  input  logic                     pop,
  output logic [W-1:0]             dout,
  output logic                     empty,
  output logic                     full,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem [DEPTH];
  logic [AW:0]  wr_ptr, rd_ptr;

  assign level = wr_ptr - rd_ptr;
  assign empty = (level == '0);
  assign full  = (level == (AW+1)'(DEPTH));
  assign dout  = mem[rd_ptr[AW-1:0]];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= din;
  end

  // Pointer update; clear empties the FIFO regardless of push/pop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/aurora_ddr_wr_packer.sv
// Packs IN_W-bit Aurora RX beats into OUT_W-bit DDR write words (lane 0 = LSB)
// and queues them in a DEPTH-word FWFT FIFO behind a valid/ready interface.
// Define PACKER_FLUSH_EN to add flush_i (emit partial word) and ddr_wr_keep_o.
module aurora_ddr_wr_packer
  import aurora_ddr_wr_pack_pkg::*;
#(
  parameter int IN_W  = 64,
  parameter int OUT_W = 512,
  parameter int DEPTH = 4
) (
  input  logic                     aurora_log_clk,
  input  logic                     aurora_rst_n,
  input  logic                     clear_i,
  input  logic                     rx_en_i,
  input  logic [IN_W-1:0]          rx_data_i,
  output logic                     ddr_wr_en_o,
  output logic [OUT_W-1:0]         ddr_wr_data_o,
  input  logic                     ddr_wr_rdy_i,
  output logic [$clog2(DEPTH):0]   fifo_level_o,
`ifdef PACKER_FLUSH_EN
  input  logic                     flush_i,
  output logic [OUT_W/IN_W-1:0]    ddr_wr_keep_o,
`endif
  output logic [31:0]              overflow_cnt_o
);
  localparam int RATIO = ratio_f(IN_W, OUT_W);
  localparam int CNT_W = cnt_w_f(RATIO);
  localparam int LVL_W = lvl_w_f(DEPTH);
`ifdef PACKER_FLUSH_EN
  localparam int FW    = OUT_W + RATIO;
`else
  localparam int FW    = OUT_W;
`endif

  logic [RATIO-1:0][IN_W-1:0] asm_q;
  logic [RATIO-1:0][IN_W-1:0] word;
  logic [CNT_W-1:0]           pack_cnt;
  logic [CNT_W:0]             lanes;
  logic                       beat_last, push_req, push, pop;
  logic                       f_empty, f_full;
  logic [FW-1:0]              f_din, f_dout;
  logic [LVL_W-1:0]           f_level;

  // Lanes filled once this cycle's beat (if any) is included.
  assign lanes     = {1'b0, pack_cnt} + (CNT_W+1)'(rx_en_i);
  assign beat_last = rx_en_i && (pack_cnt == CNT_W'(RATIO-1));

`ifdef PACKER_FLUSH_EN
  assign push_req = !clear_i && (beat_last || (flush_i && (lanes != '0)));
`else
  assign push_req = !clear_i && beat_last;
`endif

  // Outgoing word: the current beat lands in lane pack_cnt, earlier lanes come
  // from the assembly register, later lanes are zero (matters for flush).
  for (genvar k = 0; k < RATIO; k++) begin : g_lane
    assign word[k] = (rx_en_i && (pack_cnt == CNT_W'(k))) ? rx_data_i :
                     ((CNT_W'(k) < pack_cnt) ? asm_q[k] : '0);
  end

  // Pop checked first, so a full FIFO popped this cycle still takes the push.
  assign pop  = !f_empty && ddr_wr_rdy_i;
  assign push = push_req && (!f_full || pop);

`ifdef PACKER_FLUSH_EN
  assign f_din = {RATIO'(keep_mask(int'(lanes))), word};
`else
  assign f_din = word;
`endif

  aurora_ddr_wr_pack_fifo #(.W(FW), .DEPTH(DEPTH)) u_fifo (
    .clk   (aurora_log_clk),
    .rst_n (aurora_rst_n),
    .clr   (clear_i),
    .push  (push),
    .din   (f_din),
    .pop   (pop),
    .dout  (f_dout),
    .empty (f_empty),
    .full  (f_full),
    .level (f_level)
  );

  // Outputs read zero whenever nothing is queued.
  assign ddr_wr_en_o   = !f_empty;
  assign ddr_wr_data_o = f_empty ? '0 : f_dout[OUT_W-1:0];
  assign fifo_level_o  = f_level;
`ifdef PACKER_FLUSH_EN
  assign ddr_wr_keep_o = f_empty ? '0 : f_dout[FW-1:OUT_W];
`endif

  // Capture each beat into its lane of the assembly register.
  always_ff @(posedge aurora_log_clk or negedge aurora_rst_n) begin
    if (!aurora_rst_n)              asm_q <= '0;
    else if (rx_en_i && !clear_i)   asm_q[pack_cnt] <= rx_data_i;
  end

  // Lane counter: restarts on clear and after any push attempt (full or flushed).
  always_ff @(posedge aurora_log_clk or negedge aurora_rst_n) begin
    if (!aurora_rst_n)   pack_cnt <= '0;
    else if (clear_i)    pack_cnt <= '0;
    else if (push_req)   pack_cnt <= '0;
    else if (rx_en_i)    pack_cnt <= pack_cnt + 1'b1;
  end

  // Saturating count of completed words dropped on a full FIFO.
  always_ff @(posedge aurora_log_clk or negedge aurora_rst_n) begin
    if (!aurora_rst_n)                                      overflow_cnt_o <= '0;
    else if (clear_i)                                       overflow_cnt_o <= '0;
    else if (push_req && !push && (overflow_cnt_o != '1))   overflow_cnt_o <= overflow_cnt_o + 1'b1;
  end

endmodule

// File: tb/tb_aurora_ddr_wr_packer.sv
// Self-checking bench for aurora_ddr_wr_packer (default parameters).
// Flush checks are compiled in when PACKER_FLUSH_EN is defined.
module tb_aurora_ddr_wr_packer;
  localparam int IN_W = 64, OUT_W = 512, DEPTH = 4, RATIO = 8;
`ifdef PACKER_FLUSH_EN
  localparam bit FLUSH_ON = 1'b1;
`else
  localparam bit FLUSH_ON = 1'b0;
`endif

  logic              aurora_log_clk, aurora_rst_n;
  logic              clear_i, rx_en_i, ddr_wr_rdy_i, ddr_wr_en_o;
  logic [IN_W-1:0]   rx_data_i;
  logic [OUT_W-1:0]  ddr_wr_data_o;
  logic [2:0]        fifo_level_o;
  logic [31:0]       overflow_cnt_o;
`ifdef PACKER_FLUSH_EN
  logic              flush_i;
  logic [RATIO-1:0]  ddr_wr_keep_o;
`endif

  aurora_ddr_wr_packer #(.IN_W(IN_W), .OUT_W(OUT_W), .DEPTH(DEPTH)) dut (
    .aurora_log_clk (aurora_log_clk),
    .aurora_rst_n   (aurora_rst_n),
    .clear_i        (clear_i),
    .rx_en_i        (rx_en_i),
    .rx_data_i      (rx_data_i),
    .ddr_wr_en_o    (ddr_wr_en_o),
    .ddr_wr_data_o  (ddr_wr_data_o),
    .ddr_wr_rdy_i   (ddr_wr_rdy_i),
    .fifo_level_o   (fifo_level_o),
`ifdef PACKER_FLUSH_EN
    .flush_i        (flush_i),
    .ddr_wr_keep_o  (ddr_wr_keep_o),
`endif
    .overflow_cnt_o (overflow_cnt_o)
  );

  initial aurora_log_clk = 1'b0;
  always #5 aurora_log_clk = ~aurora_log_clk;

  // Reference model: beats of the word in progress, queued words, drop count.
  typedef struct { logic [OUT_W-1:0] w; logic [RATIO-1:0] k; } word_t;
  logic [IN_W-1:0] part[$];
  word_t           fq[$];
  int              m_ovf;

  int n_chk = 0, n_err = 0, dut_acc = 0;
  logic             hold_prev;
  logic [OUT_W-1:0] data_prev;

  task automatic chk(input string nm, input logic [OUT_W-1:0] act, input logic [OUT_W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic model_clear();
    part.delete(); fq.delete(); m_ovf = 0;
  endtask

  task automatic model_step(input logic en, input logic [IN_W-1:0] d, input logic rdy,
                            input logic clr, input logic fl);
    word_t x;
    if (clr) begin model_clear(); return; end
    if (fq.size() > 0 && rdy) fq.delete(0);
    if (en) part.push_back(d);
    if (part.size() == RATIO || (FLUSH_ON && fl && part.size() > 0)) begin
      x.w = '0;
      foreach (part[i]) x.w[i*IN_W +: IN_W] = part[i];
      x.k = RATIO'((9'd1 << part.size()) - 9'd1);
      if (fq.size() < DEPTH) fq.push_back(x);
      else if (m_ovf != 32'hFFFF_FFFF) m_ovf++;
      part.delete();
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_en"}, ddr_wr_en_o, fq.size() > 0);
    chk({tag, "_level"}, fifo_level_o, fq.size());
    chk({tag, "_ovf"}, overflow_cnt_o, m_ovf);
    if (fq.size() > 0) begin
      chk({tag, "_data"}, ddr_wr_data_o, fq[0].w);
`ifdef PACKER_FLUSH_EN
      chk({tag, "_keep"}, ddr_wr_keep_o, fq[0].k);
`endif
    end else begin
      chk({tag, "_data0"}, ddr_wr_data_o, '0);
    end
  endtask

  // One clock: drive, compare to model, advance model, step past the edge.
  task automatic cycle(input logic en, input logic [IN_W-1:0] d, input logic rdy,
                       input logic clr, input logic fl);
    rx_en_i = en; rx_data_i = d; ddr_wr_rdy_i = rdy; clear_i = clr;
`ifdef PACKER_FLUSH_EN
    flush_i = fl;
`endif
    check_outputs("cyc");
    if (hold_prev) chk("hold_data", ddr_wr_data_o, data_prev);
    hold_prev = ddr_wr_en_o && !rdy && !clr;
    data_prev = ddr_wr_data_o;
    if (ddr_wr_en_o && rdy && !clr) dut_acc++;
    model_step(en, d, rdy, clr, fl);
    @(posedge aurora_log_clk); #1;
  endtask

  task automatic do_reset();
    aurora_rst_n = 1'b0;
    rx_en_i = 0; rx_data_i = '0; ddr_wr_rdy_i = 0; clear_i = 0;
`ifdef PACKER_FLUSH_EN
    flush_i = 0;
`endif
    repeat (2) @(posedge aurora_log_clk);
    #1;
    model_clear();
    hold_prev = 1'b0;
    check_outputs("reset");
    aurora_rst_n = 1'b1;
  endtask

  typedef struct {
    logic en; logic [IN_W-1:0] d;
    logic exp_en; logic [IN_W-1:0] exp_l0, exp_l7; int exp_lvl;
  } vec_t;
  vec_t tv[18];
  logic [OUT_W-1:0] exp_w;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Test 1 table: beats 1..16 with rdy=1; expectations sampled after each edge.
    for (int i = 0; i < 18; i++) begin
      tv[i].en = (i < 16); tv[i].d = (i < 16) ? 64'(i + 1) : '0;
      tv[i].exp_en = 0; tv[i].exp_l0 = '0; tv[i].exp_l7 = '0; tv[i].exp_lvl = 0;
    end
    tv[7].exp_en  = 1; tv[7].exp_l0  = 64'd1; tv[7].exp_l7  = 64'd8;  tv[7].exp_lvl  = 1;
    tv[15].exp_en = 1; tv[15].exp_l0 = 64'd9; tv[15].exp_l7 = 64'd16; tv[15].exp_lvl = 1;

    do_reset();
    for (int i = 0; i < 18; i++) begin
      cycle(tv[i].en, tv[i].d, 1'b1, 1'b0, 1'b0);
      chk($sformatf("t1_en_%0d", i), ddr_wr_en_o, tv[i].exp_en);
      chk($sformatf("t1_lvl_%0d", i), fifo_level_o, tv[i].exp_lvl);
      chk($sformatf("t1_l0_%0d", i), ddr_wr_data_o[63:0], tv[i].exp_l0);
      chk($sformatf("t1_l7_%0d", i), ddr_wr_data_o[511:448], tv[i].exp_l7);
    end

    // Test 2: backpressure, 6 words into a 4-deep FIFO.
    do_reset();
    for (int b = 0; b < 48; b++) cycle(1'b1, 64'h200 + 64'(b), 1'b0, 1'b0, 1'b0);
    chk("t2_level", fifo_level_o, 4);
    chk("t2_ovf", overflow_cnt_o, 2);
    chk("t2_first_l0", ddr_wr_data_o[63:0], 64'h200);
    dut_acc = 0;
    repeat (6) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
    chk("t2_drained", dut_acc, 4);

    // Test 3: partial word discarded by clear.
    do_reset();
    for (int b = 0; b < 3; b++) cycle(1'b1, 64'h33, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'h99, 1'b0, 1'b1, 1'b0);
    for (int b = 0; b < 8; b++) cycle(1'b1, 64'hA0 + 64'(b), 1'b0, 1'b0, 1'b0);
    for (int b = 0; b < 8; b++) exp_w[b*64 +: 64] = 64'hA0 + 64'(b);
    chk("t3_word", ddr_wr_data_o, exp_w);
    chk("t3_level", fifo_level_o, 1);
    cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    // Test 4: rdy toggling, 64 continuous beats.
    do_reset();
    dut_acc = 0;
    for (int b = 0; b < 64; b++) cycle(1'b1, 64'h400 + 64'(b), (b % 2) == 0, 1'b0, 1'b0);
    for (int b = 0; b < 12; b++) cycle(1'b0, '0, (b % 2) == 0, 1'b0, 1'b0);
    chk("t4_words", dut_acc, 8);

`ifdef PACKER_FLUSH_EN
    // Test 5: flush emits a partial word with keep mask.
    do_reset();
    cycle(1'b1, 64'd5, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'd6, 1'b0, 1'b0, 1'b0);
    cycle(1'b1, 64'd7, 1'b0, 1'b0, 1'b0);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    exp_w = '0; exp_w[63:0] = 64'd5; exp_w[127:64] = 64'd6; exp_w[191:128] = 64'd7;
    chk("t5_word", ddr_wr_data_o, exp_w);
    chk("t5_keep", ddr_wr_keep_o, 8'h07);
    cycle(1'b0, '0, 1'b0, 1'b0, 1'b1);
    chk("t5_noop_level", fifo_level_o, 1);
    repeat (2) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);
`endif

    // Test 6: asynchronous reset mid-word with two words queued.
    do_reset();
    for (int b = 0; b < 20; b++) cycle(1'b1, 64'h600 + 64'(b), 1'b0, 1'b0, 1'b0);
    chk("t6_pre_level", fifo_level_o, 2);
    #2 aurora_rst_n = 1'b0;
    #1;
    chk("t6_en", ddr_wr_en_o, 0);
    chk("t6_level", fifo_level_o, 0);
    chk("t6_data", ddr_wr_data_o, '0);
    do_reset();
    for (int b = 0; b < 8; b++) cycle(1'b1, 64'h700 + 64'(b), 1'b1, 1'b0, 1'b0);
    chk("t6_fresh_l0", ddr_wr_data_o[63:0], 64'h700);

    // Randomized traffic against the model.
    do_reset();
    for (int i = 0; i < 600; i++)
      cycle($urandom_range(0, 3) != 0, {$urandom, $urandom}, $urandom_range(0, 2) == 0,
            $urandom_range(0, 99) == 0, $urandom_range(0, 15) == 0);
    repeat (8) cycle(1'b0, '0, 1'b1, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
